select_sequencer: RTL and testbench
===================================

SELECT_SEQUENCER -- requirements
Module: select_sequencer

Interface
REQ-001 SHALL have parameter DEFWAIT, default 3: reset value of every channel's wait count, range 0..15.
REQ-002 SHALL have port clock  input  1  rising-edge system clock.
REQ-003 SHALL have port reset  input  1  synchronous, active-high reset; one clock, all state sampled on clock.
REQ-004 SHALL have port start  input  1  CPU cycle request; sampled only in IDLE.
REQ-005 SHALL have port rw  input  1  cycle direction: 1 = read, 0 = write; sampled with start.
REQ-006 SHALL have port sel  input  4  selectout lines from four address-match units; sampled with start.
REQ-007 SHALL have port cfgwr  input  1  configuration register write strobe.
REQ-008 SHALL have port cfgaddr  input  2  channel config register index.
REQ-009 SHALL have port cfgdata  input  8  config write data: [3:0] wait count, [4] hold enable, [7] channel disable, [6:5] reserved.
REQ-010 SHALL have port cfgq  output  8  combinational readback of config[cfgaddr]; reserved bits read 0.
REQ-011 SHALL have port cs  output  4  one-hot chip select to the granted channel.
REQ-012 SHALL have port rdstb  output  1  read strobe.
REQ-013 SHALL have port wrstb  output  1  write strobe.
REQ-014 SHALL have port ready  output  1  one-cycle cycle-complete pulse to the CPU.
REQ-015 SHALL have port err  output  1  one-cycle pulse: no enabled channel matched.
REQ-016 SHALL have port busy  output  1  high in every state except IDLE.

Function
REQ-017 SHALL implement states IDLE, SETUP, ACCESS, HOLD, DONE, ERR; cs, rdstb, wrstb, ready, err and busy are registered, decoded from state.
REQ-018 In IDLE with start=1 at an edge: latch rw, grant the lowest index i with sel[i]=1 and config[i][7]=0, latch that channel's wait count and hold bit, go to SETUP.
REQ-019 In IDLE with start=1 and no eligible channel: go to ERR; ERR drives err=1 and ready=1 for one cycle with cs=0, then returns to IDLE.
REQ-020 SETUP: exactly one cycle; cs[granted]=1, rdstb=wrstb=0.
REQ-021 ACCESS: cs[granted]=1, rdstb=rw, wrstb=~rw; lasts latched wait+1 cycles (wait 0 gives 1 cycle, wait 15 gives 16 cycles); 4-bit down-counter, no wrap.
REQ-022 HOLD: entered after ACCESS only if the latched hold bit is 1; one cycle; cs[granted]=1, strobes 0.
REQ-023 DONE: one cycle; cs=0, strobes 0, ready=1, err=0; then IDLE.
REQ-024 Latency: start sampled at edge N; ready is high in the cycle after edge N+wait+3 (no hold) or N+wait+4 (hold); cs is high for wait+2 (no hold) or wait+3 (hold) cycles.
REQ-025 start while busy=1 SHALL be ignored, not queued; sel and rw changes during a cycle SHALL be ignored.
REQ-026 A new start sampled in the DONE or ERR cycle SHALL be ignored; the earliest accepted restart is the first IDLE cycle.
REQ-027 cfgwr at an edge SHALL write cfgdata to config[cfgaddr], accepted in any state.
REQ-028 A cycle in flight SHALL use the values latched at start; cfgwr and start on the same edge SHALL give the start the old value.
REQ-029 rdstb and wrstb SHALL never be high simultaneously; cs SHALL never have more than one bit set.

Reset
REQ-030 reset=1 at an edge, in any state including mid-cycle, SHALL force IDLE and cs=0, rdstb=0, wrstb=0, ready=0, err=0, busy=0 from the next cycle.
REQ-031 The same reset edge SHALL set every config register to {1'b0, 3'b000, DEFWAIT[3:0]}: enabled, hold off, wait=DEFWAIT.
REQ-032 reset SHALL take priority over start and cfgwr on the same edge.

Verification
REQ-033 After reset, start=1, rw=1, sel=4'b0110 -> cs=4'b0010 for 5 cycles, rdstb high for 4 cycles, ready one pulse at N+6, err=0.
REQ-034 cfgwr cfgaddr=0, cfgdata=8'h10, then write start with sel=4'b0001 -> cs=4'b0001 for 3 cycles, wrstb for 1 cycle, cfgq=8'h10 at cfgaddr=0.
REQ-035 cfgdata=8'h80 to channel 2, start with sel=4'b0100 -> err=1 and ready=1 for one cycle, cs never asserted.
REQ-036 cfgwr wait=15 to channel 3 on the same edge as start sel=4'b1000 -> old wait 3 used; the next start uses 16 ACCESS cycles.
REQ-037 reset in the second ACCESS cycle -> next cycle all outputs 0, busy=0, cfgq=8'h03 for all channels.
REQ-038 Pulse start during SETUP, ACCESS and DONE -> no extra cycle; exactly one ready per accepted start.

Source files
------------

// File: rtl/select_sequencer_if.sv
// select_sequencer_if
// Groups the CPU cycle handshake, the chip-select/strobe outputs and the
// configuration register port of the select sequencer.
//   master : CPU / bench side. Drives start, rw, sel and the cfg* write port.
//            Observes cs, rdstb, wrstb, ready, err, busy and cfgq.
//   slave  : the sequencer itself.
interface select_sequencer_if;
  logic       start;
  logic       rw;
  logic [3:0] sel;
  logic       cfgwr;
  logic [1:0] cfgaddr;
  logic [7:0] cfgdata;
  logic [7:0] cfgq;
  logic [3:0] cs;
  logic       rdstb;
  logic       wrstb;
  logic       ready;
  logic       err;
  logic       busy;

  modport master (
    output start, rw, sel, cfgwr, cfgaddr, cfgdata,
    input  cfgq, cs, rdstb, wrstb, ready, err, busy
  );

  modport slave (
    input  start, rw, sel, cfgwr, cfgaddr, cfgdata,
    output cfgq, cs, rdstb, wrstb, ready, err, busy
  );
endinterface

// File: rtl/select_sequencer.sv
// select_sequencer
// Runs one chip-select cycle per accepted CPU start: picks the lowest enabled
// channel whose address-match line is set, asserts its chip select through
// SETUP / ACCESS (wait+1 cycles) / optional HOLD, then pulses ready.
// Ports:
//   clock  - rising-edge system clock
//   reset  - synchronous active-high reset (FSM, outputs and config regs)
//   bus    - select_sequencer_if.slave: start/rw/sel in, cs/rdstb/wrstb/
//            ready/err/busy out, cfgwr/cfgaddr/cfgdata write port, cfgq readback
//
// state  | meaning
// IDLE   | waiting for start; samples rw/sel and grants a channel
// SETUP  | one cycle, chip select asserted, strobes low
// ACCESS | wait+1 cycles, chip select and read or write strobe asserted
// HOLD   | one cycle after ACCESS when the channel's hold bit is set
// DONE   | one cycle, ready pulse
// ERR    | one cycle, ready and err pulse (no eligible channel)
module select_sequencer #(
  parameter int unsigned DEFWAIT = 3
) (
  input  logic                clock,
  input  logic                reset,
  select_sequencer_if.slave   bus
);

  localparam logic [3:0] DEF_WAIT4 = 4'(DEFWAIT);

  typedef enum logic [2:0] {IDLE, SETUP, ACCESS, HOLD, DONE, ERR} state_t;

  state_t     state, state_nxt;

  logic [3:0] cfg_wait [4];
  logic [3:0] cfg_hold;
  logic [3:0] cfg_dis;
  logic       cfg_unused;

  logic       rw_q, hold_q;
  logic [1:0] gnt_q;
  logic [3:0] cnt_q;

  logic       hit;
  logic [1:0] gnt_idx;
  logic       take, cnt_dec;

  logic [3:0] cs_d, cs_q;
  logic       rd_d, rd_q, wr_d, wr_q, rdy_d, rdy_q, err_d, err_q, busy_d, busy_q;

  assign cfg_unused = ^bus.cfgdata[6:5];

  // Config register file: wait[3:0], hold[4], disable[7]; [6:5] not stored.
  always_ff @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < 4; i++) cfg_wait[i] <= DEF_WAIT4;
      cfg_hold <= '0;
      cfg_dis  <= '0;
    end else if (bus.cfgwr) begin
      cfg_wait[bus.cfgaddr] <= bus.cfgdata[3:0];
      cfg_hold[bus.cfgaddr] <= bus.cfgdata[4];
      cfg_dis[bus.cfgaddr]  <= bus.cfgdata[7];
    end
  end

  assign bus.cfgq = {cfg_dis[bus.cfgaddr], 2'b00, cfg_hold[bus.cfgaddr],
                     cfg_wait[bus.cfgaddr]};

  // Scan high to low so the lowest eligible index wins.
  always_comb begin
    hit     = 1'b0;
    gnt_idx = 2'd0;
    for (int i = 3; i >= 0; i--) begin
      if (bus.sel[i] && !cfg_dis[i]) begin
        hit     = 1'b1;
        gnt_idx = 2'(i);
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  // Outputs are a registered copy of the state decode, so the visible DONE
  // cycle coincides with the FSM already being in IDLE. busy_q guards the
  // start sample so a start seen during that visible ready cycle is dropped.
  always_comb begin
    state_nxt = state;
    take      = 1'b0;
    cnt_dec   = 1'b0;
    cs_d      = 4'b0000;
    rd_d      = 1'b0;
    wr_d      = 1'b0;
    rdy_d     = 1'b0;
    err_d     = 1'b0;
    busy_d    = (state != IDLE);
    case (state)
      IDLE: begin
        if (bus.start && !busy_q) begin
          if (hit) begin
            state_nxt = SETUP;
            take      = 1'b1;
          end else begin
            state_nxt = ERR;
          end
        end
      end
      SETUP: begin
        cs_d      = 4'b0001 << gnt_q;
        state_nxt = ACCESS;
      end
      ACCESS: begin
        cs_d = 4'b0001 << gnt_q;
        rd_d = rw_q;
        wr_d = ~rw_q;
        if (cnt_q == 4'd0) state_nxt = hold_q ? HOLD : DONE;
        else               cnt_dec   = 1'b1;
      end
      HOLD: begin
        cs_d      = 4'b0001 << gnt_q;
        state_nxt = DONE;
      end
      DONE: begin
        rdy_d     = 1'b1;
        state_nxt = IDLE;
      end
      ERR: begin
        rdy_d     = 1'b1;
        err_d     = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Cycle parameters are frozen at start; later cfg writes do not affect it.
  always_ff @(posedge clock) begin
    if (reset) begin
      rw_q   <= 1'b0;
      hold_q <= 1'b0;
      gnt_q  <= 2'd0;
      cnt_q  <= 4'd0;
    end else if (take) begin
      rw_q   <= bus.rw;
      hold_q <= cfg_hold[gnt_idx];
      gnt_q  <= gnt_idx;
      cnt_q  <= cfg_wait[gnt_idx];
    end else if (cnt_dec) begin
      cnt_q  <= cnt_q - 4'd1;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      cs_q   <= 4'b0000;
      rd_q   <= 1'b0;
      wr_q   <= 1'b0;
      rdy_q  <= 1'b0;
      err_q  <= 1'b0;
      busy_q <= 1'b0;
    end else begin
      cs_q   <= cs_d;
      rd_q   <= rd_d;
      wr_q   <= wr_d;
      rdy_q  <= rdy_d;
      err_q  <= err_d;
      busy_q <= busy_d;
    end
  end

  assign bus.cs    = cs_q;
  assign bus.rdstb = rd_q;
  assign bus.wrstb = wr_q;
  assign bus.ready = rdy_q;
  assign bus.err   = err_q;
  assign bus.busy  = busy_q;

endmodule

// File: tb/tb_select_sequencer.sv
// tb_select_sequencer
// Directed stimulus for select_sequencer. Each accepted start pushes its
// hand-computed expected outcome (granted cs, strobe direction and lengths,
// ready cycle) into a queue; a negedge monitor accumulates what the DUT shows
// and compares against the queue head on every ready pulse.
module tb_select_sequencer;

  logic clock = 1'b0;
  logic reset = 1'b1;
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;

  select_sequencer_if bus();

  select_sequencer #(.DEFWAIT(3)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus.slave)
  );

  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  typedef struct {
    logic       err;
    logic [3:0] cs;
    logic       rw;
    int         cs_len;
    int         strb_len;
    int         rdy_cyc;
  } exp_t;

  exp_t sb[$];
  exp_t e;
  logic [3:0] cs_seen;
  int cs_cnt, rd_cnt, wr_cnt;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // lat = cycles from the sampling edge to the edge after which ready shows
  task automatic push_exp(input logic e_err, input logic [3:0] e_cs, input logic e_rw,
                          input int cl, input int sl, input int lat);
    exp_t x;
    x.err = e_err; x.cs = e_cs; x.rw = e_rw;
    x.cs_len = cl; x.strb_len = sl; x.rdy_cyc = cyc + 1 + lat;
    sb.push_back(x);
  endtask

  task automatic issue(input logic r, input logic [3:0] s, input logic [3:0] e_cs,
                       input int cl, input int sl, input int lat, input logic e_err);
    bus.rw = r; bus.sel = s; bus.start = 1'b1;
    push_exp(e_err, e_cs, r, cl, sl, lat);
    tick();
    bus.start = 1'b0; bus.sel = 4'hF; bus.rw = ~r;
  endtask

  task automatic cfg_write(input logic [1:0] a, input logic [7:0] d);
    bus.cfgaddr = a; bus.cfgdata = d; bus.cfgwr = 1'b1;
    tick();
    bus.cfgwr = 1'b0;
  endtask

  task automatic wait_done(input int max);
    int n;
    n = 0;
    while ((sb.size() != 0 || bus.busy) && n < max) begin
      tick();
      n++;
    end
    if (n >= max) begin
      checks++; errors++;
      $display("FAIL wait_done: timeout with %0d pending, busy %0b", sb.size(), bus.busy);
    end
  endtask

  task automatic chk_idle_outputs(input string name);
    chk(name, {bus.cs, bus.rdstb, bus.wrstb, bus.ready, bus.err, bus.busy}, 32'h0);
  endtask

  task automatic chk_cfg_defaults();
    for (int a = 0; a < 4; a++) begin
      bus.cfgaddr = 2'(a);
      #1;
      chk("cfgq_default", bus.cfgq, 8'h03);
    end
  endtask

  always @(negedge clock) begin
    if (reset) begin
      sb.delete();
      cs_seen = 4'b0; cs_cnt = 0; rd_cnt = 0; wr_cnt = 0;
    end else begin
      checks++;
      if ((bus.rdstb && bus.wrstb) || ($countones(bus.cs) > 1) || (bus.err && !bus.ready)) begin
        errors++;
        $display("FAIL invariant: cs %b rd %b wr %b err %b ready %b (cycle %0d)",
                 bus.cs, bus.rdstb, bus.wrstb, bus.err, bus.ready, cyc);
      end
      if (bus.cs != 4'b0) begin
        cs_cnt++;
        cs_seen = cs_seen | bus.cs;
      end
      if (bus.rdstb) rd_cnt++;
      if (bus.wrstb) wr_cnt++;
      if (bus.ready) begin
        if (sb.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_ready: ready with empty queue (cycle %0d)", cyc);
        end else begin
          e = sb.pop_front();
          chk("err", 32'(bus.err), 32'(e.err));
          chk("cs_sel", 32'(cs_seen), 32'(e.cs));
          chk("cs_len", cs_cnt, e.cs_len);
          chk("rd_len", rd_cnt, e.rw ? e.strb_len : 0);
          chk("wr_len", wr_cnt, e.rw ? 0 : e.strb_len);
          chk("ready_cyc", cyc, e.rdy_cyc);
        end
        cs_seen = 4'b0; cs_cnt = 0; rd_cnt = 0; wr_cnt = 0;
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    bus.start = 1'b0; bus.rw = 1'b0; bus.sel = 4'b0;
    bus.cfgwr = 1'b0; bus.cfgaddr = 2'd0; bus.cfgdata = 8'h00;
    repeat (3) tick();
    reset = 1'b0;
    chk_idle_outputs("reset_outputs");
    chk_cfg_defaults();

    // default wait 3, lowest of sel 0110 is channel 1
    issue(1'b1, 4'b0110, 4'b0010, 5, 4, 6, 1'b0);
    wait_done(40);

    // channel 0: wait 0, hold on
    cfg_write(2'd0, 8'h10);
    bus.cfgaddr = 2'd0; #1;
    chk("cfgq_ch0", bus.cfgq, 8'h10);
    issue(1'b0, 4'b0001, 4'b0001, 3, 1, 4, 1'b0);
    wait_done(40);

    // channel 2 disabled
    cfg_write(2'd2, 8'h80);
    bus.cfgaddr = 2'd2; #1;
    chk("cfgq_ch2", bus.cfgq, 8'h80);
    issue(1'b1, 4'b0100, 4'b0000, 0, 0, 1, 1'b1);
    wait_done(40);
    issue(1'b0, 4'b0000, 4'b0000, 0, 0, 1, 1'b1);
    wait_done(40);
    issue(1'b1, 4'b1100, 4'b1000, 5, 4, 6, 1'b0);
    wait_done(40);

    // cfg write and start on the same edge: start uses old wait 3
    bus.cfgaddr = 2'd3; bus.cfgdata = 8'h0F; bus.cfgwr = 1'b1;
    bus.rw = 1'b0; bus.sel = 4'b1000; bus.start = 1'b1;
    push_exp(1'b0, 4'b1000, 1'b0, 5, 4, 6);
    tick();
    bus.cfgwr = 1'b0; bus.start = 1'b0; bus.sel = 4'hF; bus.rw = 1'b1;
    wait_done(40);
    bus.cfgaddr = 2'd3; #1;
    chk("cfgq_ch3", bus.cfgq, 8'h0F);
    issue(1'b1, 4'b1000, 4'b1000, 17, 16, 18, 1'b0);
    wait_done(60);

    // reserved bits are not stored
    cfg_write(2'd1, 8'h62);
    bus.cfgaddr = 2'd1; #1;
    chk("cfgq_reserved", bus.cfgq, 8'h02);

    // starts while busy are dropped; first idle cycle accepts a restart
    bus.rw = 1'b1; bus.sel = 4'b0010; bus.start = 1'b1;
    push_exp(1'b0, 4'b0010, 1'b1, 4, 3, 5);
    tick();                    // edge N accepts
    tick();                    // edge N+1, SETUP
    bus.start = 1'b0;
    tick();
    bus.start = 1'b1;
    tick();                    // edge N+3, ACCESS
    bus.start = 1'b0;
    tick();
    tick();                    // ready visible after edge N+5
    bus.start = 1'b1;
    tick();                    // edge N+6, ready cycle: ignored
    bus.rw = 1'b0;
    push_exp(1'b0, 4'b0010, 1'b0, 4, 3, 5);
    tick();                    // edge N+7, first idle cycle: accepted
    bus.start = 1'b0; bus.sel = 4'hF;
    wait_done(40);

    // reset in the second ACCESS cycle, with start and cfgwr on the same edge
    issue(1'b1, 4'b1000, 4'b1000, 17, 16, 18, 1'b0);
    tick();
    tick();
    tick();
    chk("rd_before_reset", 32'(bus.rdstb), 32'h1);
    reset = 1'b1;
    bus.start = 1'b1; bus.sel = 4'b0001;
    bus.cfgaddr = 2'd1; bus.cfgdata = 8'h8F; bus.cfgwr = 1'b1;
    tick();
    chk_idle_outputs("reset_midcycle");
    reset = 1'b0; bus.start = 1'b0; bus.cfgwr = 1'b0;
    tick();
    chk_idle_outputs("after_reset");
    chk_cfg_defaults();
    issue(1'b1, 4'b0001, 4'b0001, 5, 4, 6, 1'b0);
    wait_done(40);

    chk("sb_empty", sb.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
